led_phase_scheduler: RTL and testbench

Time-multiplexes the single LED/PGA/ADC analog front end between the RED and IR channels once calibration has produced per-channel DC compensation and PGA settings. It drives the LEDs and the active DC_Comp/PGA_Gain in fixed-length phases and blanks ADC samples while the front end settles. It averages the valid samples in each phase and publishes one RED/IR value pair per frame over a valid/ready handshake to the downstream SpO2 processing.

---
 rtl/led_phase_scheduler_pkg.sv | 34 +++
 rtl/led_phase_scheduler_phase_averager.sv | 48 ++++
 rtl/led_phase_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_led_phase_scheduler.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_phase_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// led_phase_scheduler_pkg
// Types and constants for the LED phase scheduler. The calibration controller
// imports this package as well, so the DC_Comp/PGA widths are defined here
// once.
//   phase_state_t      : scheduler state encoding
//   DC_W / PGA_W       : DC compensation and PGA gain widths
//   ADC_W              : front-end sample width
//   DEF_*              : default phase timing parameters
//   sat_sub()          : subtraction clamped at zero (ambient cancel)
// ----------------------------------------------------------------------------
package led_phase_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RED  = 2'd1,
        ST_IR   = 2'd2,
        ST_DARK = 2'd3
    } phase_state_t;

    localparam int DC_W              = 7;
    localparam int PGA_W             = 4;
    localparam int ADC_W             = 8;

    localparam int DEF_PHASE_CYCLES  = 10;
    localparam int DEF_SETTLE_CYCLES = 3;
    localparam int DEF_AVG_LOG2      = 2;

    function automatic logic [ADC_W-1:0] sat_sub(input logic [ADC_W-1:0] a,
                                                 input logic [ADC_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/led_phase_scheduler_phase_averager.sv
// ----------------------------------------------------------------------------
// phase_averager
// Accumulates ADC samples while the phase counter sits inside the averaging
// window and presents the truncated mean. One instance serves every phase;
// the scheduler clears it on each phase entry.
//   CLK, rst_n  : clock, async active-low reset
//   i_clear     : clear the accumulator on this edge (wins over accumulate)
//   i_cnt       : current phase counter
//   i_adc       : front-end sample
//   o_avg       : accumulator >> AVG_LOG2
// ----------------------------------------------------------------------------
module phase_averager
    import led_phase_scheduler_pkg::*;
#(
    parameter int CNT_W         = 4,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int AVG_LOG2      = DEF_AVG_LOG2
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [ADC_W-1:0] i_adc,
    output logic [ADC_W-1:0] o_avg
);

    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam logic [CNT_W-1:0] WIN_LO = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] WIN_HI = CNT_W'(SETTLE_CYCLES + (1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] r_acc;
    logic             w_in_window;

    assign w_in_window = (i_cnt >= WIN_LO) && (i_cnt <= WIN_HI);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (w_in_window) begin
            r_acc <= r_acc + ACC_W'(i_adc);
        end
    end

    assign o_avg = r_acc[ACC_W-1:AVG_LOG2];

endmodule

// File: rtl/led_phase_scheduler.sv
// ----------------------------------------------------------------------------
// led_phase_scheduler
// Time-multiplexes the LED/PGA/ADC front end between RED and IR (and an
// optional dark phase), averages the settled ADC samples of each phase and
// publishes one RED/IR pair per frame over valid/ready.
//
// Build option: AMBIENT_CANCEL_EN adds a dark phase whose average is
// subtracted (clamped at 0) from both channel averages.
//
// Ports: CLK, rst_n (async, active-low); enable; cfg_load + red/ir dc_comp/pga
// staging inputs; ADC sample; LED_RED, LED_IR, DC_Comp, PGA_Gain front-end
// drive; red_value, ir_value, pair_valid, pair_ready handshake; overrun.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | front end parked, LEDs off, RED settings shown
// ST_RED  | RED LED on, active RED settings, RED samples averaged
// ST_IR   | IR LED on, active IR settings, IR samples averaged
// ST_DARK | LEDs off, ambient level averaged (AMBIENT_CANCEL_EN only)
// ----------------------------------------------------------------------------
module led_phase_scheduler
    import led_phase_scheduler_pkg::*;
#(
    parameter int PHASE_CYCLES  = DEF_PHASE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int AVG_LOG2      = DEF_AVG_LOG2
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cfg_load,
    input  logic [DC_W-1:0]  red_dc_comp,
    input  logic [PGA_W-1:0] red_pga,
    input  logic [DC_W-1:0]  ir_dc_comp,
    input  logic [PGA_W-1:0] ir_pga,
    input  logic [ADC_W-1:0] ADC,
    output logic             LED_RED,
    output logic             LED_IR,
    output logic [DC_W-1:0]  DC_Comp,
    output logic [PGA_W-1:0] PGA_Gain,
    output logic [ADC_W-1:0] red_value,
    output logic [ADC_W-1:0] ir_value,
    output logic             pair_valid,
    input  logic             pair_ready,
    output logic             overrun
);

    localparam int CNT_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PHASE_CYCLES - 1);

    phase_state_t     r_state;
    phase_state_t     w_next;
    logic [CNT_W-1:0] r_cnt;

    logic [DC_W-1:0]  r_stg_red_dc, r_stg_ir_dc, r_act_red_dc, r_act_ir_dc;
    logic [PGA_W-1:0] r_stg_red_pga, r_stg_ir_pga, r_act_red_pga, r_act_ir_pga;
    logic [ADC_W-1:0] r_red_avg;

    logic             w_boundary;
    logic             w_step;
    logic             w_last_phase;
    logic             w_publish;
    logic             w_clear;
    logic [ADC_W-1:0] w_avg;
    logic [ADC_W-1:0] w_pub_red;
    logic [ADC_W-1:0] w_pub_ir;

    assign w_boundary = (r_state != ST_IDLE) && (r_cnt == LAST_CNT);
    assign w_step     = w_boundary || ((r_state == ST_IDLE) && enable);
    assign w_publish  = w_boundary && w_last_phase;
    // Holding the accumulator clear through IDLE makes every phase start at 0.
    assign w_clear    = (r_state == ST_IDLE) || w_boundary;

`ifdef AMBIENT_CANCEL_EN
    logic [ADC_W-1:0] r_ir_avg;

    assign w_last_phase = (r_state == ST_DARK);
    assign w_pub_red    = sat_sub(r_red_avg, w_avg);
    assign w_pub_ir     = sat_sub(r_ir_avg, w_avg);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_ir_avg <= '0;
        end else if ((r_state == ST_IR) && w_boundary) begin
            r_ir_avg <= w_avg;
        end
    end
`else
    assign w_last_phase = (r_state == ST_IR);
    assign w_pub_red    = r_red_avg;
    assign w_pub_ir     = w_avg;
`endif

    always_comb begin
        w_next = r_state;
        if (!enable && w_boundary) begin
            w_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: if (enable) w_next = ST_RED;
                ST_RED:  if (w_boundary) w_next = ST_IR;
`ifdef AMBIENT_CANCEL_EN
                ST_IR:   if (w_boundary) w_next = ST_DARK;
                ST_DARK: if (w_boundary) w_next = ST_RED;
`else
                ST_IR:   if (w_boundary) w_next = ST_RED;
                ST_DARK: w_next = ST_IDLE;
`endif
                default: w_next = ST_IDLE;
            endcase
        end
    end

    phase_averager #(
        .CNT_W         (CNT_W),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .AVG_LOG2      (AVG_LOG2)
    ) u_avg (
        .CLK     (CLK),
        .rst_n   (rst_n),
        .i_clear (w_clear),
        .i_cnt   (r_cnt),
        .i_adc   (ADC),
        .o_avg   (w_avg)
    );

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_stg_red_dc  <= '0;
            r_stg_red_pga <= '0;
            r_stg_ir_dc   <= '0;
            r_stg_ir_pga  <= '0;
            r_act_red_dc  <= '0;
            r_act_red_pga <= '0;
            r_act_ir_dc   <= '0;
            r_act_ir_pga  <= '0;
            r_red_avg     <= '0;
            LED_RED       <= 1'b0;
            LED_IR        <= 1'b0;
            DC_Comp       <= '0;
            PGA_Gain      <= '0;
            red_value     <= '0;
            ir_value      <= '0;
            pair_valid    <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            if (cfg_load) begin
                r_stg_red_dc  <= red_dc_comp;
                r_stg_red_pga <= red_pga;
                r_stg_ir_dc   <= ir_dc_comp;
                r_stg_ir_pga  <= ir_pga;
                overrun       <= 1'b0;
            end

            if ((r_state == ST_RED) && w_boundary) begin
                r_red_avg <= w_avg;
            end

            // A publish on the acceptance edge simply reloads; only an
            // unaccepted pending pair counts as overwritten.
            if (w_publish) begin
                red_value  <= w_pub_red;
                ir_value   <= w_pub_ir;
                pair_valid <= 1'b1;
                if (pair_valid && !pair_ready) begin
                    overrun <= 1'b1;
                end
            end else if (pair_valid && pair_ready) begin
                pair_valid <= 1'b0;
            end

            if (w_step) begin
                r_state <= w_next;
                r_cnt   <= '0;
                unique case (w_next)
                    ST_RED: begin
                        // RED is only entered at frame start, so staging is
                        // committed here and never mid-frame.
                        r_act_red_dc  <= r_stg_red_dc;
                        r_act_red_pga <= r_stg_red_pga;
                        r_act_ir_dc   <= r_stg_ir_dc;
                        r_act_ir_pga  <= r_stg_ir_pga;
                        LED_RED       <= 1'b1;
                        LED_IR        <= 1'b0;
                        DC_Comp       <= r_stg_red_dc;
                        PGA_Gain      <= r_stg_red_pga;
                    end
                    ST_IR: begin
                        LED_RED  <= 1'b0;
                        LED_IR   <= 1'b1;
                        DC_Comp  <= r_act_ir_dc;
                        PGA_Gain <= r_act_ir_pga;
                    end
                    default: begin
                        LED_RED  <= 1'b0;
                        LED_IR   <= 1'b0;
                        DC_Comp  <= r_act_red_dc;
                        PGA_Gain <= r_act_red_pga;
                    end
                endcase
            end else if (r_state != ST_IDLE) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_led_phase_scheduler.sv
module tb_led_phase_scheduler;

    localparam int PH = 10;
`ifdef AMBIENT_CANCEL_EN
    localparam int NPH = 3;
`else
    localparam int NPH = 2;
`endif
    localparam int FR = PH * NPH;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       cfg_load;
    logic [6:0] red_dc_comp;
    logic [3:0] red_pga;
    logic [6:0] ir_dc_comp;
    logic [3:0] ir_pga;
    logic [7:0] ADC;
    logic       LED_RED;
    logic       LED_IR;
    logic [6:0] DC_Comp;
    logic [3:0] PGA_Gain;
    logic [7:0] red_value;
    logic [7:0] ir_value;
    logic       pair_valid;
    logic       pair_ready;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;
    int pos;
    int mode;

    led_phase_scheduler dut (
        .CLK         (CLK),
        .rst_n       (rst_n),
        .enable      (enable),
        .cfg_load    (cfg_load),
        .red_dc_comp (red_dc_comp),
        .red_pga     (red_pga),
        .ir_dc_comp  (ir_dc_comp),
        .ir_pga      (ir_pga),
        .ADC         (ADC),
        .LED_RED     (LED_RED),
        .LED_IR      (LED_IR),
        .DC_Comp     (DC_Comp),
        .PGA_Gain    (PGA_Gain),
        .red_value   (red_value),
        .ir_value    (ir_value),
        .pair_valid  (pair_valid),
        .pair_ready  (pair_ready),
        .overrun     (overrun)
    );

    always #5 CLK = ~CLK;

    // pos = edges since the run left IDLE; the cycle after edge pos has
    // phase counter (pos-1)%PH and phase index ((pos-1)/PH)%NPH.
    function automatic logic [7:0] adc_val();
        int idx;
        if (pos == 0) return 8'd0;
        if (mode == 0) return 8'd100;
        if (mode == 1) return 8'((pos - 1) % PH);
        idx = ((pos - 1) / PH) % NPH;
        if (idx == 0) return 8'd90;
        if (idx == 1) return 8'd150;
        return 8'd100;
    endfunction

    task automatic drive_adc();
        ADC = adc_val();
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
            pos++;
            drive_adc();
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

`ifdef AMBIENT_CANCEL_EN
    localparam int EXP_CONST_R = 0;
    localparam int EXP_CONST_I = 0;
    localparam int EXP_RAMP    = 0;
    localparam int EXP_AMB_R   = 0;
    localparam int EXP_AMB_I   = 50;
`else
    localparam int EXP_CONST_R = 100;
    localparam int EXP_CONST_I = 100;
    localparam int EXP_RAMP    = 4;
    localparam int EXP_AMB_R   = 90;
    localparam int EXP_AMB_I   = 150;
`endif

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        cfg_load    = 1'b0;
        red_dc_comp = 7'd0;
        red_pga     = 4'd0;
        ir_dc_comp  = 7'd0;
        ir_pga      = 4'd0;
        pair_ready  = 1'b0;
        pos         = 0;
        mode        = 0;
        drive_adc();

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_led_red", int'(LED_RED), 0);
        chk("rst_led_ir", int'(LED_IR), 0);
        chk("rst_dc", int'(DC_Comp), 0);
        chk("rst_pga", int'(PGA_Gain), 0);
        chk("rst_red_value", int'(red_value), 0);
        chk("rst_ir_value", int'(ir_value), 0);
        chk("rst_valid", int'(pair_valid), 0);
        chk("rst_overrun", int'(overrun), 0);

        rst_n       = 1'b1;
        red_dc_comp = 7'd40;
        red_pga     = 4'd5;
        ir_dc_comp  = 7'd60;
        ir_pga      = 4'd9;
        cfg_load    = 1'b1;
        @(posedge CLK);
        #1;
        cfg_load = 1'b0;
        chk("idle_dc_after_cfg", int'(DC_Comp), 0);

        // Constant ADC run.
        enable = 1'b1;
        pos    = 0;
        drive_adc();
        step(1);
        chk("red_entry_led", int'(LED_RED), 1);
        chk("red_entry_dc", int'(DC_Comp), 40);
        chk("red_entry_pga", int'(PGA_Gain), 5);
        step(PH - 1);
        chk("red_last_dc", int'(DC_Comp), 40);
        step(1);
        chk("ir_entry_led_ir", int'(LED_IR), 1);
        chk("ir_entry_led_red", int'(LED_RED), 0);
        chk("ir_entry_dc", int'(DC_Comp), 60);
        chk("ir_entry_pga", int'(PGA_Gain), 9);
        step(FR - PH - 1);
        chk("pre_publish_valid", int'(pair_valid), 0);
        step(1);
        chk("pub1_valid", int'(pair_valid), 1);
        chk("pub1_red", int'(red_value), EXP_CONST_R);
        chk("pub1_ir", int'(ir_value), EXP_CONST_I);
        chk("pub1_dc", int'(DC_Comp), 40);

        // Ramp within each phase; pair left unconsumed -> overrun.
        mode = 1;
        drive_adc();
        step(FR);
        chk("pub2_valid", int'(pair_valid), 1);
        chk("pub2_overrun", int'(overrun), 1);
        chk("pub2_red_ramp", int'(red_value), EXP_RAMP);
        chk("pub2_ir_ramp", int'(ir_value), EXP_RAMP);

        // cfg_load mid-RED: clears overrun, current frame keeps old settings.
        step(4);
        red_dc_comp = 7'd10;
        red_pga     = 4'd2;
        cfg_load    = 1'b1;
        step(1);
        cfg_load = 1'b0;
        chk("cfg_clr_overrun", int'(overrun), 0);
        chk("midframe_dc", int'(DC_Comp), 40);
        chk("midframe_pga", int'(PGA_Gain), 5);
        step(PH - 1);
        chk("midframe_ir_dc", int'(DC_Comp), 60);
        step(FR - 14);
        chk("newcfg_dc", int'(DC_Comp), 10);
        chk("newcfg_pga", int'(PGA_Gain), 2);
        chk("overrun_again", int'(overrun), 1);
        cfg_load = 1'b1;
        step(1);
        cfg_load = 1'b0;
        chk("overrun_cleared", int'(overrun), 0);

        // Accept on the same edge as the next publish.
        step(FR - 2);
        pair_ready = 1'b1;
        step(1);
        chk("accpub_valid", int'(pair_valid), 1);
        chk("accpub_overrun", int'(overrun), 0);
        step(1);
        chk("accepted_valid", int'(pair_valid), 0);
        pair_ready = 1'b0;

        // enable low at a mid-frame boundary: IDLE, no publish.
        enable = 1'b0;
        step(PH - 1);
        chk("abort_led_red", int'(LED_RED), 0);
        chk("abort_led_ir", int'(LED_IR), 0);
        chk("abort_dc", int'(DC_Comp), 10);
        chk("abort_pga", int'(PGA_Gain), 2);
        chk("abort_valid", int'(pair_valid), 0);
        step(PH);
        chk("idle_valid", int'(pair_valid), 0);
        chk("idle_led_ir", int'(LED_IR), 0);

        // Per-phase levels; enable drops in the last phase -> publish, then IDLE.
        mode   = 2;
        enable = 1'b1;
        pos    = 0;
        drive_adc();
        step(1);
        chk("restart_dc", int'(DC_Comp), 10);
        chk("restart_led", int'(LED_RED), 1);
        step(FR - 5);
        enable = 1'b0;
        step(5);
        chk("amb_valid", int'(pair_valid), 1);
        chk("amb_red", int'(red_value), EXP_AMB_R);
        chk("amb_ir", int'(ir_value), EXP_AMB_I);
        chk("amb_idle_led_red", int'(LED_RED), 0);
        chk("amb_idle_led_ir", int'(LED_IR), 0);
        step(3);
        chk("amb_stays_idle", int'(LED_RED), 0);

        // Asynchronous reset mid-phase.
        enable = 1'b1;
        step(4);
        rst_n = 1'b0;
        #1;
        chk("async_rst_led", int'(LED_RED), 0);
        chk("async_rst_valid", int'(pair_valid), 0);
        chk("async_rst_dc", int'(DC_Comp), 0);
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
